button_event: RTL and testbench
===============================

# button_event

Converts a debounced push-button level (output of the team's debounce stage) into one-cycle event pulses: press, release, long-press and auto-repeat. It sits between the debouncer and the game/control FSMs, which consume only single-cycle strobes and never sample raw button levels. Also keeps a wrapping press counter for display and diagnostics.

## Interface
- LONG_CYCLES, 50_000_000 — cycles pb_deb must stay high after the press event before long_pulse; legal range ≥ 2
- REPEAT_CYCLES, 10_000_000 — period of repeat_pulse once long-press is reached; legal range ≥ 2
- REPEAT_EN, 1 — 1 enables auto-repeat; 0 means no repeat_pulse ever fires
- clk  in  1  system clock; reset rst_n, asynchronous, active-low; clock clk
- rst_n  in  1  asynchronous active-low reset
- pb_deb  in  1  debounced button level, synchronous to clk, 1 = pressed
- press_pulse  out  1  one-cycle strobe on accepted press
- release_pulse  out  1  one-cycle strobe on release of an accepted press
- long_pulse  out  1  one-cycle strobe when hold reaches LONG_CYCLES
- repeat_pulse  out  1  one-cycle strobe every REPEAT_CYCLES after long_pulse
- held  out  1  high while an accepted press is active (state ≠ IDLE)
- press_count  out  8  number of accepted presses, wraps 255 → 0

## Operation
- Internal counter width = $clog2(max(LONG_CYCLES, REPEAT_CYCLES)); counter unsigned, never exceeds the active limit minus 1.
- Arming flag `armed`: cleared at reset, set on the first clock edge where pb_deb = 0. Presses are not accepted while armed = 0, so a button held through reset produces no events until released and pressed again.
- States: IDLE, PRESSED, LONG.
- IDLE: if armed and pb_deb = 1 → PRESSED, cnt ← 0, press_pulse ← 1, press_count ← press_count + 1.
- PRESSED: if pb_deb = 0 → IDLE, release_pulse ← 1. Else if cnt = LONG_CYCLES−1 → LONG, cnt ← 0, long_pulse ← 1. Else cnt ← cnt + 1.
- LONG: if pb_deb = 0 → IDLE, release_pulse ← 1. Else if REPEAT_EN and cnt = REPEAT_CYCLES−1 → cnt ← 0, repeat_pulse ← 1. Else cnt ← cnt + 1 (held at 0 when REPEAT_EN = 0).
- Release has priority over long/repeat on the same edge: no long_pulse or repeat_pulse is generated on the edge that sees pb_deb = 0.
- At most one of the four pulses is high in any cycle.
- held = (state ≠ IDLE), registered with state.

## Timing
- All outputs registered; reset values: press_pulse, release_pulse, long_pulse, repeat_pulse, held = 0; press_count = 0; state IDLE; cnt = 0; armed = 0.
- Press latency: pb_deb high before edge k (armed) → press_pulse and held high in cycle following edge k, press_pulse for exactly one cycle.
- long_pulse asserts exactly LONG_CYCLES clock edges after the edge that asserted press_pulse, if pb_deb stays high throughout.
- repeat_pulse asserts REPEAT_CYCLES edges after long_pulse, then every REPEAT_CYCLES edges.
- release_pulse asserts on the first edge sampling pb_deb = 0 in PRESSED/LONG; held falls on the same edge.
- Minimum press-to-press spacing: a release followed by pb_deb = 1 on the next edge is a new press (IDLE accepts immediately); no lockout.
- Reset mid-operation: all outputs return to reset values asynchronously; any pending long/repeat is lost; armed cleared.

## Test plan
- LONG_CYCLES=8, REPEAT_CYCLES=4: reset with pb_deb=0, raise pb_deb for 3 cycles → press_pulse 1 cycle, held 3 cycles, release_pulse 1 cycle, no long_pulse, press_count = 1.
- Same params, hold pb_deb 20 cycles → long_pulse 8 edges after press_pulse, repeat_pulse at +4, +8 after long_pulse (edges 12, 16 rel. press), release_pulse after drop; exactly one of each strobe per cycle.
- Drop pb_deb on the edge where cnt = 7 in PRESSED → release_pulse only, no long_pulse; same test at cnt = 3 in LONG → no repeat_pulse.
- Hold pb_deb = 1 through reset release for 10 cycles → no events, held = 0; drop then raise → press_pulse, press_count = 1.
- REPEAT_EN=0, hold 30 cycles → one long_pulse, zero repeat_pulse.
- 256 short presses → press_count wraps to 0; assert rst_n low while in LONG → all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/button_event.sv
// button_event: turns a debounced button level into single-cycle press,
// release, long-press and auto-repeat strobes, plus a wrapping press counter.
module button_event #(
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter bit          REPEAT_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pb_deb,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       held,
  output logic [7:0] press_count
);

  localparam int unsigned MAX_CYC = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;
  logic          press_pulse_q, press_pulse_d;
  logic          release_pulse_q, release_pulse_d;
  logic          long_pulse_q, long_pulse_d;
  logic          repeat_pulse_q, repeat_pulse_d;
  logic          held_q, held_d;
  logic [7:0]    press_count_q, press_count_d;

  // State, counter, arming flag and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      armed_q         <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      long_pulse_q    <= 1'b0;
      repeat_pulse_q  <= 1'b0;
      held_q          <= 1'b0;
      press_count_q   <= 8'd0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      armed_q         <= armed_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      long_pulse_q    <= long_pulse_d;
      repeat_pulse_q  <= repeat_pulse_d;
      held_q          <= held_d;
      press_count_q   <= press_count_d;
    end
  end

  // Next state and hold counter; release wins over long/repeat
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    armed_d = armed_q | ~pb_deb;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (armed_q && pb_deb) state_d = PRESSED;
      end
      PRESSED: begin
        if (!pb_deb) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          state_d = LONG;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      LONG: begin
        if (!pb_deb) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!REPEAT_EN || cnt_q == REP_LAST) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Strobe and status values to be registered alongside the state
  always_comb begin
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    long_pulse_d    = 1'b0;
    repeat_pulse_d  = 1'b0;
    held_d          = (state_d != IDLE);
    press_count_d   = press_count_q;
    case (state_q)
      IDLE: begin
        if (armed_q && pb_deb) begin
          press_pulse_d = 1'b1;
          press_count_d = press_count_q + 8'd1;
        end
      end
      PRESSED: begin
        if (!pb_deb)                 release_pulse_d = 1'b1;
        else if (cnt_q == LONG_LAST) long_pulse_d    = 1'b1;
      end
      LONG: begin
        if (!pb_deb)                             release_pulse_d = 1'b1;
        else if (REPEAT_EN && cnt_q == REP_LAST) repeat_pulse_d  = 1'b1;
      end
      default: ;
    endcase
  end

  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign long_pulse    = long_pulse_q;
  assign repeat_pulse  = repeat_pulse_q;
  assign held          = held_q;
  assign press_count   = press_count_q;

endmodule

// File: tb/tb_button_event.sv
// Bench for button_event: two instances (auto-repeat on and off) share the
// stimulus and are checked every cycle against a hold-duration model.
module tb_button_event;

  localparam int L = 8;
  localparam int R = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pb_deb = 1'b0;

  logic       pr_a, rl_a, lg_a, rp_a, hd_a;
  logic [7:0] pc_a;
  logic       pr_b, rl_b, lg_b, rp_b, hd_b;
  logic [7:0] pc_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  button_event #(.LONG_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .pb_deb(pb_deb),
    .press_pulse(pr_a), .release_pulse(rl_a), .long_pulse(lg_a),
    .repeat_pulse(rp_a), .held(hd_a), .press_count(pc_a)
  );

  button_event #(.LONG_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_EN(1'b0)) dut_nr (
    .clk(clk), .rst_n(rst_n), .pb_deb(pb_deb),
    .press_pulse(pr_b), .release_pulse(rl_b), .long_pulse(lg_b),
    .repeat_pulse(rp_b), .held(hd_b), .press_count(pc_b)
  );

  // Reference model: index 0 = repeat enabled, 1 = repeat disabled
  bit       m_armed [2];
  bit       m_held  [2];
  int       m_h     [2];
  bit [7:0] m_cnt   [2];
  bit [12:0] m_exp  [2];
  int n_long [2];
  int n_rep  [2];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_armed[i] = 0; m_held[i] = 0; m_h[i] = 0; m_cnt[i] = 0; m_exp[i] = '0;
    end
  endfunction

  // Expected outputs after the next edge, given the level sampled there
  function automatic void model_step(input bit v);
    for (int i = 0; i < 2; i++) begin
      bit e_pr, e_rl, e_lg, e_rp;
      e_pr = 0; e_rl = 0; e_lg = 0; e_rp = 0;
      if (!m_held[i]) begin
        if (m_armed[i] && v) begin
          m_held[i] = 1; m_h[i] = 0; e_pr = 1; m_cnt[i] = m_cnt[i] + 8'd1;
        end
      end else if (!v) begin
        m_held[i] = 0; e_rl = 1;
      end else begin
        m_h[i]++;
        if (m_h[i] == L) e_lg = 1;
        else if (i == 0 && m_h[i] > L && ((m_h[i] - L) % R) == 0) e_rp = 1;
      end
      if (!v) m_armed[i] = 1;
      m_exp[i] = {e_pr, e_rl, e_lg, e_rp, m_held[i], m_cnt[i]};
    end
  endfunction

  // One clock: drive level, advance model, check both instances after the edge
  task automatic cycle(input bit v);
    bit [12:0] act_a, act_b;
    pb_deb = v;
    model_step(v);
    @(posedge clk);
    #1;
    act_a = {pr_a, rl_a, lg_a, rp_a, hd_a, pc_a};
    act_b = {pr_b, rl_b, lg_b, rp_b, hd_b, pc_b};
    n_long[0] += int'(lg_a); n_rep[0] += int'(rp_a);
    n_long[1] += int'(lg_b); n_rep[1] += int'(rp_b);
    total++;
    if (act_a !== m_exp[0]) begin
      bad++;
      $display("FAIL outputs_rep t=%0t got=%b want=%b (press,rel,long,rep,held,count)", $time, act_a, m_exp[0]);
    end
    total++;
    if (act_b !== m_exp[1]) begin
      bad++;
      $display("FAIL outputs_norep t=%0t got=%b want=%b (press,rel,long,rep,held,count)", $time, act_b, m_exp[1]);
    end
    total++;
    if ($countones({pr_a, rl_a, lg_a, rp_a}) > 1) begin
      bad++;
      $display("FAIL one_hot_pulse t=%0t got=%b want at most one set", $time, {pr_a, rl_a, lg_a, rp_a});
    end
  endtask

  task automatic hold(input bit v, input int n);
    for (int k = 0; k < n; k++) cycle(v);
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 2; i++) begin n_long[i] = 0; n_rep[i] = 0; end
  endtask

  // Asynchronous reset away from the edge; outputs must clear before any edge
  task automatic apply_reset(input bit v);
    pb_deb = v;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({pr_a, rl_a, lg_a, rp_a, hd_a, pc_a, pr_b, rl_b, lg_b, rp_b, hd_b, pc_b} !== '0) begin
      bad++;
      $display("FAIL async_reset t=%0t got a=%b b=%b want all zero", $time,
               {pr_a, rl_a, lg_a, rp_a, hd_a, pc_a}, {pr_b, rl_b, lg_b, rp_b, hd_b, pc_b});
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset(1'b0);
    hold(1'b0, 2);
  endtask

  task automatic test_short_press();
    clear_stats();
    hold(1'b1, 3);
    hold(1'b0, 2);
    total++;
    if (pc_a !== 8'd1 || n_long[0] != 0) begin
      bad++;
      $display("FAIL short_press count=%0d longs=%0d want count=1 longs=0", pc_a, n_long[0]);
    end
  endtask

  task automatic test_long_repeat();
    clear_stats();
    hold(1'b1, 20);
    hold(1'b0, 2);
    total++;
    if (n_long[0] != 1 || n_rep[0] != 2) begin
      bad++;
      $display("FAIL long_repeat longs=%0d reps=%0d want 1 and 2", n_long[0], n_rep[0]);
    end
  endtask

  task automatic test_release_boundary();
    clear_stats();
    hold(1'b1, L);          // drop lands on the edge with cnt = L-1
    hold(1'b0, 2);
    total++;
    if (n_long[0] != 0) begin
      bad++;
      $display("FAIL release_before_long longs=%0d want 0", n_long[0]);
    end
    clear_stats();
    hold(1'b1, L + R);      // drop lands on the edge with cnt = R-1 in LONG
    hold(1'b0, 2);
    total++;
    if (n_long[0] != 1 || n_rep[0] != 0) begin
      bad++;
      $display("FAIL release_before_repeat longs=%0d reps=%0d want 1 and 0", n_long[0], n_rep[0]);
    end
  endtask

  task automatic test_held_through_reset();
    clear_stats();
    apply_reset(1'b1);
    hold(1'b1, 10);
    total++;
    if (hd_a !== 1'b0 || pc_a !== 8'd0 || n_long[0] != 0) begin
      bad++;
      $display("FAIL held_through_reset held=%b count=%0d longs=%0d want 0 0 0", hd_a, pc_a, n_long[0]);
    end
    hold(1'b0, 1);
    hold(1'b1, 1);
    total++;
    if (pr_a !== 1'b1 || pc_a !== 8'd1) begin
      bad++;
      $display("FAIL rearm_press press=%b count=%0d want 1 1", pr_a, pc_a);
    end
    hold(1'b0, 2);
  endtask

  task automatic test_no_repeat();
    clear_stats();
    hold(1'b1, 30);
    hold(1'b0, 2);
    total++;
    if (n_long[1] != 1 || n_rep[1] != 0) begin
      bad++;
      $display("FAIL no_repeat longs=%0d reps=%0d want 1 and 0", n_long[1], n_rep[1]);
    end
  endtask

  task automatic test_back_to_back_wrap();
    apply_reset(1'b0);
    hold(1'b0, 1);
    for (int k = 0; k < 256; k++) begin
      cycle(1'b1);
      cycle(1'b0);
    end
    total++;
    if (pc_a !== 8'd0 || pc_b !== 8'd0) begin
      bad++;
      $display("FAIL count_wrap got=%0d/%0d want 0", pc_a, pc_b);
    end
  endtask

  task automatic test_reset_in_long();
    hold(1'b1, L + 3);
    total++;
    if (hd_a !== 1'b1) begin
      bad++;
      $display("FAIL in_long_setup held=%b want 1", hd_a);
    end
    apply_reset(1'b1);
    hold(1'b1, 3);
    hold(1'b0, 2);
  endtask

  task automatic test_random();
    for (int k = 0; k < 150; k++) begin
      bit v;
      int n;
      v = 1'($urandom_range(0, 1));
      n = (($urandom_range(0, 3)) == 0) ? int'($urandom_range(6, 25)) : int'($urandom_range(1, 5));
      if ($urandom_range(0, 40) == 0) apply_reset(v);
      hold(v, n);
    end
  endtask

  initial begin
    clear_stats();
    model_reset();
    test_reset();
    test_short_press();
    test_long_repeat();
    test_release_boundary();
    test_held_through_reset();
    test_no_repeat();
    test_back_to_back_wrap();
    test_reset_in_long();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
